fir_decim_requant: RTL
======================

// Module: fir_decim_requant
// PURPOSE
//  Downstream stage of the pipelined low-pass FIR filter.
//  - Takes the filter's full-precision signed accumulator once per clk.
//  - Keeps every DECIM-th sample and arithmetic-shifts it back to Q31.
//  - Saturates to 32 bits and buffers results in a small FIFO with a valid/ready output.
//  - Lets the anti-aliased stream leave at the decimated rate toward a DMA/serialiser consumer.
// PARAMETERS
//  IN_W   64  width of signed input accumulator
//  OUT_W  32  width of signed output sample
//  SHIFT  31  arithmetic right shift applied to input (Q-format restore)
//  DECIM  4   decimation factor, >=1 (1 = keep every sample)
//  DEPTH  8   output FIFO depth, power of two, >=2
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset, asynchronous, active-high
//  in_valid   in   1          in_data holds a filter sample this cycle
//  in_data    in   IN_W       signed filter accumulator
//  out_valid  out  1          FIFO head valid
//  out_ready  in   1          consumer accepts head this cycle
//  out_data   out  OUT_W      signed Q31 decimated sample
//  fill       out  clog2(DEPTH)+1  FIFO occupancy
//  sat_cnt    out  16         saturated-sample count, sticks at 16'hFFFF
//  overrun    out  1          sticky: a kept sample was dropped because the FIFO was full
//  clr_flags  in   1          sync clear of sat_cnt and overrun
// BEHAVIOUR
//  Reset (async, rst=1): all outputs 0, phase=0, FIFO empty, stage-1 reg invalid. Reset mid-stream discards buffered data.
//  Phase counter
//   - Advances only when in_valid=1; wraps DECIM-1 -> 0.
//   - Sample is kept when phase==0, so the first valid after reset is kept.
//   - in_valid=0 leaves phase unchanged.
//  Stage 1 (registered), for a kept sample:
//   - t = in_data >>> SHIFT, computed at IN_W.
//   - t > 2^(OUT_W-1)-1 -> max; t < -2^(OUT_W-1) -> min; either case increments sat_cnt (saturating at 16'hFFFF).
//  Stage 2: stage-1 result written to FIFO.
//  Latency: kept sample at edge n -> out_valid=1 with that data after edge n+2 (FIFO empty).
//  Handshake
//   - Pop when out_valid & out_ready.
//   - out_data stable while out_valid & !out_ready.
//   - out_valid never depends combinationally on out_ready.
//  Full FIFO
//   - Write accepted if fill<DEPTH, or a pop occurs in the same cycle (fill unchanged).
//   - Otherwise the sample is dropped and overrun is set.
//  Empty FIFO: out_ready ignored; fill never underflows.
//  Pointers: wrap modulo DEPTH.
//  clr_flags
//   - Clears sat_cnt and overrun next edge.
//   - A saturation or drop in the same cycle wins: sat_cnt=1 / overrun=1.
//   - Does not touch FIFO contents or phase.
// CONFIGURATION
//  FIR_DECIM_ROUND_EN
//   - Defined: round half up before the shift: t = (in_data + (1<<(SHIFT-1))) >>> SHIFT.
//     The add is done at IN_W+1 bits so it cannot wrap; applies only when SHIFT>0.
//   - Undefined: plain truncation toward -inf (>>>).
//   - Latency, handshake and saturation rules are identical in both builds.
// TESTING
//  T1 reset: rst pulsed mid-stream with 3 entries buffered -> out_valid=0, fill=0, sat_cnt=0, overrun=0 immediately, without waiting for a clock edge.
//  T2 decimation
//   - Stimulus: DECIM=4, out_ready=1, in_valid=1, in_data = k<<31 for k=0..11.
//   - Response: outputs 0,4,8 in order.
//   - Each output appears 2 cycles after its input.
//  T3 saturation
//   - Stimulus: in_data=64'sh7FFF_FFFF_FFFF_FFFF, then 64'sh8000_0000_0000_0000.
//   - Response: out_data=32'h7FFF_FFFF, then 32'h8000_0000; sat_cnt=2.
//  T4 rounding
//   - Stimulus: in_data=64'h0000_0000_C000_0000 (1.5).
//   - Response: out_data=1 without FIR_DECIM_ROUND_EN; 2 with it.
//   - Stimulus: in_data=-1.5 (64'hFFFF_FFFF_4000_0000).
//   - Response: -2 without; -1 with.
//  T5 backpressure
//   - Stimulus: DECIM=1, DEPTH=8, out_ready=0, 10 samples.
//   - Response: fill=8, overrun=1, samples 8-9 lost.
//   - Then out_ready=1: samples 0-7 are drained in order with no bubbles.
//  T6 full + pop
//   - Stimulus: FIFO full, write and pop in the same cycle.
//   - Response: fill stays 8, no overrun; the new sample is the last one drained.
//   - clr_flags pulse clears the sticky flags.

Source files
------------

// File: rtl/fir_decim_requant.sv
// Decimating requantiser: keeps every DECIM-th filter accumulator, shifts it back to Q31,
// saturates and buffers it in a valid/ready FIFO. Define FIR_DECIM_ROUND_EN for round-half-up.
module fir_decim_requant #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int SHIFT = 31,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [IN_W-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [15:0]                sat_cnt,
  output logic                       overrun,
  input  logic                       clr_flags
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  // One guard bit so the rounding add can never wrap
  localparam int TW = IN_W + 1;

  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = {{(TW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [TW-1:0] RND =
    (SHIFT > 0) ? (TW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

  logic [PW-1:0]        phase;
  logic                 keep;
  logic signed [TW-1:0] ext;
  logic signed [TW-1:0] t;
  logic [OUT_W-1:0]     q_val;
  logic                 q_sat;
  logic                 sat_ev;

  logic                 s1_valid;
  logic [OUT_W-1:0]     s1_data;

  logic [OUT_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign keep   = in_valid && (phase == '0);
  assign sat_ev = keep && q_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
    end
  end

  always_comb begin
    ext = $signed({in_data[IN_W-1], in_data});
`ifdef FIR_DECIM_ROUND_EN
    t = (ext + RND) >>> SHIFT;
`else
    t = ext >>> SHIFT;
`endif
    q_sat = 1'b0;
    q_val = t[OUT_W-1:0];
    if (t > SAT_MAX) begin
      q_sat = 1'b1;
      q_val = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (t < SAT_MIN) begin
      q_sat = 1'b1;
      q_val = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) s1_data <= q_val;
    end
  end

  // A fresh event in the clearing cycle survives the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (clr_flags) begin
      sat_cnt <= sat_ev ? 16'd1 : 16'd0;
    end else if (sat_ev && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_flags) begin
      overrun <= 1'b0;
    end
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign pop  = (count != '0) && out_ready;
  assign push = s1_valid && ((count != (AW+1)'(DEPTH)) || pop);
  assign drop = s1_valid && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s1_data;
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? $signed(mem[rd_ptr]) : '0;
  assign fill      = count;

endmodule
